// File: rtl/cw_iambic_keyer.sv
// cw_iambic_keyer: straight / iambic A / iambic B CW keyer with millisecond element timing.
// Dot length is floor(1200/wpm), produced by a serial restoring divider.
module cw_iambic_keyer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        millisec_pulse,
  input  logic        dot_paddle,
  input  logic        dash_paddle,
  input  logic        cw_keys_reversed,
  input  logic [1:0]  cw_keyer_mode,
  input  logic [5:0]  cw_keyer_speed,
  output logic        keyer_out,
  output logic        keyer_busy,
  output logic [11:0] dot_ms
);
  typedef enum logic [1:0] {IDLE, DOT_ON, DASH_ON, GAP} state_t;
  state_t      state_q, state_d;
  logic [5:0]  spd, spd_q, spd_d, rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] quo_q, quo_d;
  logic [6:0]  trial;
  logic        fits;
  logic [11:0] dot_ms_q, dot_ms_d, timer_q, timer_d;
  logic        dot_mem_q, dot_mem_d, dash_mem_q, dash_mem_d, last_dash_q, last_dash_d;
  logic        mode_b_q, mode_b_d, key_q, key_d, busy_q, busy_d;
  logic        dp, ap, straight, dot_pend, dash_pend, tick_end, prefer_dot, go_dot, go_dash;

  assign spd = (cw_keyer_speed == 6'd0) ? 6'd1 : (cw_keyer_speed > 6'd60) ? 6'd60 : cw_keyer_speed;
  assign trial = {rem_q, quo_q[10]};
  assign fits = trial >= {1'b0, spd_q};

  always_comb begin
    spd_d = spd_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dot_ms_d = dot_ms_q;
    if (spd != spd_q) begin
      spd_d = spd;
      cnt_d = 4'd11;
      rem_d = '0;
      quo_d = 11'd1200;
    end else if (cnt_q != 4'd0) begin
      rem_d = fits ? 6'(trial - {1'b0, spd_q}) : trial[5:0];
      quo_d = {quo_q[9:0], fits};
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) dot_ms_d = {1'b0, quo_d};
    end
  end

  assign dp = cw_keys_reversed ? dash_paddle : dot_paddle;
  assign ap = cw_keys_reversed ? dot_paddle : dash_paddle;
  assign straight = cw_keyer_mode == 2'd0 || cw_keyer_mode == 2'd3;
  assign dot_pend = dp | dot_mem_q;
  assign dash_pend = ap | dash_mem_q;
  assign tick_end = millisec_pulse && timer_q == 12'd1;
  // From IDLE dots win a squeeze; leaving GAP the element opposite the last one wins.
  assign prefer_dot = state_q == IDLE || last_dash_q;
  assign go_dot = dot_pend && (prefer_dot || !dash_pend);
  assign go_dash = dash_pend && !go_dot;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dot_mem_d = dot_mem_q;
    dash_mem_d = dash_mem_q;
    last_dash_d = last_dash_q;
    mode_b_d = mode_b_q;
    if (straight) begin
      state_d = IDLE;
      timer_d = '0;
      dot_mem_d = 1'b0;
      dash_mem_d = 1'b0;
    end else begin
      if (state_q != IDLE && mode_b_q) begin
        if (state_q == DOT_ON || (state_q == GAP && !last_dash_q)) dash_mem_d = dash_mem_q | ap;
        if (state_q == DASH_ON || (state_q == GAP && last_dash_q)) dot_mem_d = dot_mem_q | dp;
      end
      if (millisec_pulse && state_q != IDLE) timer_d = timer_q - 12'd1;
      if (state_q == IDLE || (state_q == GAP && tick_end)) begin
        mode_b_d = cw_keyer_mode == 2'd2;
        state_d = go_dot ? DOT_ON : go_dash ? DASH_ON : IDLE;
        timer_d = go_dot ? dot_ms_q : go_dash ? dot_ms_q + {dot_ms_q[10:0], 1'b0} : 12'd0;
        if (go_dot || !mode_b_d) dot_mem_d = 1'b0;
        if (go_dash || !mode_b_d) dash_mem_d = 1'b0;
      end else if ((state_q == DOT_ON || state_q == DASH_ON) && tick_end) begin
        state_d = GAP;
        timer_d = dot_ms_q;
        last_dash_d = state_q == DASH_ON;
      end
    end
    key_d = straight ? dp : (state_q == DOT_ON || state_q == DASH_ON);
    busy_d = !straight && state_q != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      dot_mem_q <= 1'b0;
      dash_mem_q <= 1'b0;
      last_dash_q <= 1'b1;
      mode_b_q <= 1'b0;
      key_q <= 1'b0;
      busy_q <= 1'b0;
      spd_q <= 6'd20;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dot_ms_q <= 12'd60;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dot_mem_q <= dot_mem_d;
      dash_mem_q <= dash_mem_d;
      last_dash_q <= last_dash_d;
      mode_b_q <= mode_b_d;
      key_q <= key_d;
      busy_q <= busy_d;
      spd_q <= spd_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dot_ms_q <= dot_ms_d;
    end
  end

  assign keyer_out = key_q;
  assign keyer_busy = busy_q;
  assign dot_ms = dot_ms_q;
endmodule

// File: doc/cw_iambic_keyer.md
CW_IAMBIC_KEYER -- requirements
Module: cw_iambic_keyer

Interface
REQ-001 The block SHALL have no parameters; all timing SHALL be derived from millisec_pulse and cw_keyer_speed.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- millisec_pulse  in  1  one-clk strobe, once per ms.
- dot_paddle  in  1  debounced dot paddle, active-high.
- dash_paddle  in  1  debounced dash paddle, active-high.
- cw_keys_reversed  in  1  1 = swap dot/dash paddles before all other logic.
- cw_keyer_mode  in  2  0 straight, 1 iambic A, 2 iambic B, 3 treated as 0.
- cw_keyer_speed  in  6  words per minute.
- keyer_out  out  1  registered key-down; drives the downstream CW sequencer key input.
- keyer_busy  out  1  1 when the state machine is not IDLE.
- dot_ms  out  12  current dot length in ms, for status readback.

Function
REQ-003 Speed SHALL be clamped to 1..60: 0 maps to 1, and values above 60 map to 60.
REQ-004 dot_ms SHALL equal floor(1200/clamped speed), computed by a sequential restoring divider of at most 12 clk cycles.
REQ-005 The divider SHALL restart whenever the clamped speed differs from the value it last latched, and dot_ms SHALL update only on divider completion.
REQ-006 Element lengths SHALL be captured at element entry: dot = dot_ms, dash = 3*dot_ms, gap = dot_ms (12-bit).
REQ-007 A speed change mid-element SHALL NOT alter the element or gap in progress.
REQ-008 The states SHALL be IDLE, DOT_ON, DASH_ON and GAP, with keyer_out = 1 only in DOT_ON and DASH_ON.
REQ-009 Timer behaviour:
- On state entry, the timer SHALL load the length.
- On each millisec_pulse, the timer SHALL decrement.
- On the millisec_pulse at which timer == 1, the state SHALL advance in the same clk.
REQ-010 IDLE transitions, evaluated every clk:
- dot pending goes to DOT_ON.
- Otherwise, dash pending goes to DASH_ON.
- Simultaneous first press of both paddles SHALL start with DOT_ON.
REQ-011 DOT_ON and DASH_ON SHALL go to GAP, recording last_element.
REQ-012 GAP exit priority:
- The opposite element of last_element, if pending, is taken first.
- Otherwise the same element, if pending.
- Otherwise IDLE.
REQ-013 Pending definitions:
- dot pending = dot paddle OR dot memory.
- dash pending = dash paddle OR dash memory.
REQ-014 Mode B memory: during DOT_ON/DASH_ON/GAP, a press of the paddle opposite to the current/last element SHALL set that element's memory.
REQ-015 Mode A: the memories SHALL stay 0, and only live paddle levels at GAP exit SHALL count.
REQ-016 An element's memory SHALL clear on entry to that element.
REQ-017 Mode 0/3 (straight) behaviour:
- The state SHALL be forced to IDLE.
- Memories and timer SHALL clear.
- keyer_out SHALL equal the swapped dot paddle, delayed 1 clk.
REQ-018 A mode change to 0/3 mid-element SHALL take effect on the next clk.
REQ-019 A mode change between 1 and 2 SHALL take effect at the next GAP exit.
REQ-020 keyer_out latency SHALL be 1 clk from state change; keyer_busy SHALL be registered alongside it.

Reset
REQ-021 Asynchronous assertion of rst_n = 0 SHALL immediately force:
- state IDLE, keyer_out 0, keyer_busy 0;
- memories 0, timer 0, last_element = dash;
- dot_ms = 60, with the divider latch holding 20.
REQ-022 After release, the divider SHALL start on the first clk, and paddles SHALL be honoured from the first clk.
REQ-023 Reset asserted mid-element SHALL truncate the element, with no residual memory.

Verification
REQ-024 Speed 20 WPM, mode 1, dot held -> keyer_out alternates 60 ms on / 60 ms off for as long as the paddle is held; release mid-GAP -> returns to IDLE at gap end with no further element.
REQ-025 Speed 20 WPM, mode 2, dot pressed and both paddles squeezed during the first dot, both released during that dot -> dot 60 ms, gap 60 ms, dash 180 ms, gap 60 ms, then IDLE; the same stimulus in mode 1 -> single dot then IDLE.
REQ-026 Speed sweep: 0 -> dot_ms 1200; 1 -> 1200; 13 -> 92; 60 -> 20; 63 -> 20; dot_ms stable within 12 clk; a speed change during a 180 ms dash -> the dash still lasts 180 ms.
REQ-027 cw_keys_reversed = 1, mode 1, dot_paddle held at 30 WPM -> repeated 120 ms dashes with 40 ms gaps.
REQ-028 Mode 0 -> keyer_out follows dot_paddle 1 clk late with dash_paddle ignored; switch mode 2 -> 0 mid-dash -> keyer_out follows the paddle on the next clk and keyer_busy = 0.
REQ-029 rst_n pulsed low mid-dash -> keyer_out = 0 asynchronously; after release, dot_ms = 60 until the divider completes for the current speed.
